multiplication_float_32: RTL and testbench
==========================================

MULTIPLICATION_FLOAT_32 -- requirements
Module: multiplication_float_32

Interface
REQ-001 SHALL have parameter ROUND_NEAREST, default 1, meaning 1 = round-to-nearest-even and 0 = truncate toward zero.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port operand1  input  32  IEEE-754 single multiplicand; captured when start is accepted.
REQ-006 SHALL have port operand2  input  32  IEEE-754 single multiplier; captured when start is accepted.
REQ-007 SHALL have port result  output  32  IEEE-754 single product; registered.
REQ-008 SHALL have port finish  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port illegal  output  1  set with finish on NaN/Inf operand or exponent overflow.
REQ-010 SHALL have port busy  output  1  high from accept until the finish cycle, inclusive.

Function
REQ-011 SHALL implement states IDLE, UNPACK, MULT, NORM, PACK, DONE.
REQ-012 In IDLE with start=1 at an edge: SHALL latch both operands, set busy, and move to UNPACK.
REQ-013 UNPACK SHALL split sign/exponent/fraction, add the hidden 1 for nonzero exponents, and treat exponent 0 (zero or denormal) as zero.
REQ-014 UNPACK SHALL compute sign = s1 XOR s2 and a 10-bit signed exponent e1 + e2 - 127.
REQ-015 MULT SHALL run exactly 24 cycles of shift-add, one multiplier bit per cycle LSB first, into a 48-bit product register, counted by a 5-bit counter.
REQ-016 NORM (1 cycle): if product bit 47 = 1, SHALL shift right one and increment the exponent; mantissa = bits [46:23], guard/sticky from the lower bits.
REQ-017 PACK (1 cycle) SHALL round per ROUND_NEAREST; a rounding carry out of the mantissa SHALL renormalise and increment the exponent.
REQ-018 Fixed latency: start accepted at edge k -> finish=1 for exactly the cycle after edge k+28; the same latency applies for special cases.
REQ-019 DONE SHALL drive finish=1 for one cycle and clear busy, then return to IDLE.
REQ-020 result and illegal SHALL hold until the next accepted start completes.
REQ-021 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-022 start held high continuously SHALL be accepted in the IDLE cycle following DONE.
REQ-023 Either operand zero and neither NaN/Inf: result = {sign, 31'b0} (signed zero), illegal=0.
REQ-024 Either operand exponent 255 (NaN or Inf): result = 32'h7fc00000, illegal=1.
REQ-025 Final exponent >= 255: result = {sign, 8'hff, 23'b0}, illegal=1.
REQ-026 Final exponent <= 0: result = {sign, 31'b0} (flush to zero), illegal=0.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, result=0, finish=0, illegal=0, busy=0, counter=0, product=0.
REQ-028 Reset asserted mid-operation SHALL abort it with no finish pulse; the first start after reset_n rises SHALL be processed normally.

Verification
REQ-029 Normal: 32'h40400000 x 32'h3f000000 -> result 32'h3fc00000, illegal 0, finish exactly 28 cycles after accept.
REQ-030 Sign: 32'h40000000 x 32'hc0900000 -> result 32'hc1100000, illegal 0.
REQ-031 Rounding: 32'h3f800001 x 32'h3f800001 -> result 32'h3f800002 with ROUND_NEAREST=1 and 32'h3f800002 with ROUND_NEAREST=0 (2^-46 term discarded either way).
REQ-032 Zero and underflow: 32'h80000000 x 32'h40600000 -> 32'h80000000, illegal 0; 32'h00800000 x 32'h00800000 -> 32'h00000000, illegal 0.
REQ-033 Exceptions: 32'h7fc00000 x 32'h3f800000 -> 32'h7fc00000, illegal 1; 32'h7f000000 x 32'h40000000 -> 32'h7f800000, illegal 1.
REQ-034 Control: start pulsed during MULT is ignored with no result change and a single finish; reset_n pulsed low in MULT gives all outputs 0 and no finish, then the next start completes correctly.

Source files
------------

// File: rtl/multiplication_float_32.sv
//------------------------------------------------------------------------------
// multiplication_float_32
//   Sequential IEEE-754 single-precision multiplier (shift-add, 28-cycle latency).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multiplication_float_32 #(
  parameter int ROUND_NEAREST = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic [31:0] result,
  output logic        finish,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    PACK   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        op1_q, op1_d;
  logic [31:0]        op2_q, op2_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        m1_q, m1_d;
  logic [23:0]        m2_q, m2_d;
  logic [47:0]        prod_q, prod_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               special_q, special_d;
  logic               zero_q, zero_d;
  logic [23:0]        mant_q, mant_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        pend_res_q, pend_res_d;
  logic               pend_ill_q, pend_ill_d;
  logic [31:0]        result_q, result_d;
  logic               finish_q, finish_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, busy_d;

  logic [7:0]         e1, e2;
  logic [24:0]        add_sum;
  logic               round_up;
  logic [24:0]        mant_r;
  logic [22:0]        frac_r;
  logic signed [9:0]  exp_r;

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    m1_d       = m1_q;
    m2_d       = m2_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    special_d  = special_q;
    zero_d     = zero_q;
    mant_d     = mant_q;
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    pend_res_d = pend_res_q;
    pend_ill_d = pend_ill_q;
    result_d   = result_q;
    illegal_d  = illegal_q;
    finish_d   = 1'b0;
    busy_d     = busy_q;
    e1         = op1_q[30:23];
    e2         = op2_q[30:23];
    add_sum    = '0;
    round_up   = 1'b0;
    mant_r     = '0;
    frac_r     = '0;
    exp_r      = exp_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op1_d   = operand1;
          op2_d   = operand2;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        sign_d    = op1_q[31] ^ op2_q[31];
        exp_d     = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
        m1_d      = (e1 != 8'd0) ? {1'b1, op1_q[22:0]} : 24'd0;
        m2_d      = (e2 != 8'd0) ? {1'b1, op2_q[22:0]} : 24'd0;
        special_d = (e1 == 8'hff) || (e2 == 8'hff);
        zero_d    = (e1 == 8'd0) || (e2 == 8'd0);
        prod_d    = '0;
        cnt_d     = '0;
        state_d   = MULT;
      end

      MULT: begin
        // Accumulate into the upper half, then shift the whole register right
        // so multiplier bit i ends up weighted by 2^i after 24 steps.
        add_sum = {1'b0, prod_q[47:24]} + {1'b0, (m2_q[0] ? m1_q : 24'd0)};
        prod_d  = {add_sum, prod_q[23:1]};
        m2_d    = m2_q >> 1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          state_d = NORM;
        end
      end

      NORM: begin
        if (prod_q[47]) begin
          mant_d   = prod_q[47:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          mant_d   = prod_q[46:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
        end
        state_d = PACK;
      end

      PACK: begin
        round_up = (ROUND_NEAREST != 0) && guard_q && (sticky_q || mant_q[0]);
        mant_r   = {1'b0, mant_q} + {24'd0, round_up};
        if (mant_r[24]) begin
          frac_r = mant_r[23:1];
          exp_r  = exp_q + 10'sd1;
        end else begin
          frac_r = mant_r[22:0];
          exp_r  = exp_q;
        end

        if (special_q) begin
          pend_res_d = 32'h7fc00000;
          pend_ill_d = 1'b1;
        end else if (zero_q) begin
          pend_res_d = {sign_q, 31'd0};
          pend_ill_d = 1'b0;
        end else if (exp_r >= 10'sd255) begin
          pend_res_d = {sign_q, 8'hff, 23'd0};
          pend_ill_d = 1'b1;
        end else if (exp_r <= 10'sd0) begin
          pend_res_d = {sign_q, 31'd0};
          pend_ill_d = 1'b0;
        end else begin
          pend_res_d = {sign_q, exp_r[7:0], frac_r};
          pend_ill_d = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        result_d  = pend_res_q;
        illegal_d = pend_ill_q;
        finish_d  = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy stays up through the finish cycle; a new accept there re-arms it.
    if ((state_q == IDLE) && start) begin
      busy_d = 1'b1;
    end else if (finish_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      special_q  <= 1'b0;
      zero_q     <= 1'b0;
      mant_q     <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      pend_res_q <= '0;
      pend_ill_q <= 1'b0;
      result_q   <= '0;
      finish_q   <= 1'b0;
      illegal_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      special_q  <= special_d;
      zero_q     <= zero_d;
      mant_q     <= mant_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      pend_res_q <= pend_res_d;
      pend_ill_q <= pend_ill_d;
      result_q   <= result_d;
      finish_q   <= finish_d;
      illegal_q  <= illegal_d;
      busy_q     <= busy_d;
    end
  end

  assign result  = result_q;
  assign finish  = finish_q;
  assign illegal = illegal_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplication_float_32.sv
//------------------------------------------------------------------------------
// tb_multiplication_float_32
//   Randomised and directed bench for both rounding modes of the multiplier.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multiplication_float_32;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [31:0] result_n, result_t;
  logic        finish_n, finish_t;
  logic        illegal_n, illegal_t;
  logic        busy_n, busy_t;

  int n_cmp = 0;
  int n_err = 0;

  multiplication_float_32 #(.ROUND_NEAREST(1)) dut_n (
    .clock(clock), .reset_n(reset_n), .start(start),
    .operand1(operand1), .operand2(operand2),
    .result(result_n), .finish(finish_n), .illegal(illegal_n), .busy(busy_n)
  );

  multiplication_float_32 #(.ROUND_NEAREST(0)) dut_t (
    .clock(clock), .reset_n(reset_n), .start(start),
    .operand1(operand1), .operand2(operand2),
    .result(result_t), .finish(finish_t), .illegal(illegal_t), .busy(busy_t)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Reference product from real-number rules: exact 48-bit mantissa product,
  // remainder compared against one half ulp for nearest-even.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit rn);
    int          ea, eb, e;
    logic [47:0] p;
    logic [24:0] keep;
    logic [23:0] rem, half;
    logic [7:0]  ee;
    logic        s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (ea == 255 || eb == 255) return {1'b1, 32'h7fc00000};
    if (ea == 0 || eb == 0) return {1'b0, s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      e++;
      keep = {1'b0, p[47:24]};
      rem  = p[23:0];
      half = 24'h800000;
    end else begin
      keep = {1'b0, p[46:23]};
      rem  = {1'b0, p[22:0]};
      half = 24'h400000;
    end
    if (rn && ((rem > half) || ((rem == half) && keep[0]))) keep = keep + 25'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) return {1'b1, s, 8'hff, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    ee = e[7:0];
    return {1'b0, s, ee, keep[22:0]};
  endfunction

  // Issues one operation and waits for finish; lat = edges from accept to finish.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r_n, output logic [31:0] r_t,
                        output logic il_n, output logic il_t, output int lat);
    lat = -1;
    @(negedge clock);
    start    = 1'b1;
    operand1 = a;
    operand2 = b;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (j == 1) start = 1'b0;
      if (finish_n) begin
        lat = j - 1;
        break;
      end
    end
    r_n  = result_n;
    r_t  = result_t;
    il_n = illegal_n;
    il_t = illegal_t;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    operand1 = '0;
    operand2 = '0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({result_n, finish_n, illegal_n, busy_n} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs_rn: got %h/%b/%b/%b want 0", result_n, finish_n, illegal_n, busy_n);
    end
    n_cmp++;
    if ({result_t, finish_t, illegal_t, busy_t} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs_tr: got %h/%b/%b/%b want 0", result_t, finish_t, illegal_t, busy_t);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({finish_n, busy_n, result_n} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_release_idle: got fin=%b busy=%b res=%h want 0", finish_n, busy_n, result_n);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic        vi [8];
    logic [31:0] r_n, r_t;
    logic        il_n, il_t;
    int          lat;
    va[0] = 32'h40400000; vb[0] = 32'h3f000000; vr[0] = 32'h3fc00000; vi[0] = 1'b0;
    va[1] = 32'h40000000; vb[1] = 32'hc0900000; vr[1] = 32'hc1100000; vi[1] = 1'b0;
    va[2] = 32'h3f800001; vb[2] = 32'h3f800001; vr[2] = 32'h3f800002; vi[2] = 1'b0;
    va[3] = 32'h80000000; vb[3] = 32'h40600000; vr[3] = 32'h80000000; vi[3] = 1'b0;
    va[4] = 32'h00800000; vb[4] = 32'h00800000; vr[4] = 32'h00000000; vi[4] = 1'b0;
    va[5] = 32'h7fc00000; vb[5] = 32'h3f800000; vr[5] = 32'h7fc00000; vi[5] = 1'b1;
    va[6] = 32'h7f000000; vb[6] = 32'h40000000; vr[6] = 32'h7f800000; vi[6] = 1'b1;
    va[7] = 32'h3f800000; vb[7] = 32'h7f800000; vr[7] = 32'h7fc00000; vi[7] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], r_n, r_t, il_n, il_t, lat);
      n_cmp++;
      if (lat !== 28) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d want 28", i, lat);
      end
      n_cmp++;
      if ({il_n, r_n} !== {vi[i], vr[i]}) begin
        n_err++;
        $display("FAIL directed_rn[%0d]: %h*%h got ill=%b res=%h want ill=%b res=%h",
                 i, va[i], vb[i], il_n, r_n, vi[i], vr[i]);
      end
      n_cmp++;
      if ({il_t, r_t} !== {vi[i], vr[i]}) begin
        n_err++;
        $display("FAIL directed_tr[%0d]: %h*%h got ill=%b res=%h want ill=%b res=%h",
                 i, va[i], vb[i], il_t, r_t, vi[i], vr[i]);
      end
      @(negedge clock);
      n_cmp++;
      if (finish_n !== 1'b0 || busy_n !== 1'b0) begin
        n_err++;
        $display("FAIL directed_pulse[%0d]: got fin=%b busy=%b want 0/0", i, finish_n, busy_n);
      end
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({illegal_n, result_n} !== {vi[i], vr[i]}) begin
        n_err++;
        $display("FAIL directed_hold[%0d]: got ill=%b res=%h want ill=%b res=%h",
                 i, illegal_n, result_n, vi[i], vr[i]);
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    int mode;
    mode = int'($urandom_range(0, 15));
    if (mode == 0)       e = 8'd0;
    else if (mode == 1)  e = 8'hff;
    else if (mode <= 3)  e = 8'($urandom_range(1, 20));
    else if (mode <= 5)  e = 8'($urandom_range(230, 254));
    else                 e = 8'($urandom_range(90, 165));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic test_random();
    logic [31:0] a, b, r_n, r_t;
    logic        il_n, il_t;
    logic [32:0] exp_n, exp_t;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = rand_operand();
      b = rand_operand();
      if (i % 8 == 0) b = {b[31:23], a[22:0]};
      exp_n = ref_mul(a, b, 1'b1);
      exp_t = ref_mul(a, b, 1'b0);
      run_op(a, b, r_n, r_t, il_n, il_t, lat);
      n_cmp++;
      if (lat !== 28 || {il_n, r_n} !== exp_n) begin
        n_err++;
        $display("FAIL random_rn[%0d]: %h*%h got lat=%0d ill=%b res=%h want lat=28 ill=%b res=%h",
                 i, a, b, lat, il_n, r_n, exp_n[32], exp_n[31:0]);
      end
      n_cmp++;
      if ({il_t, r_t} !== exp_t) begin
        n_err++;
        $display("FAIL random_tr[%0d]: %h*%h got ill=%b res=%h want ill=%b res=%h",
                 i, a, b, il_t, r_t, exp_t[32], exp_t[31:0]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int          nf, lat;
    logic [31:0] r;
    logic        busy_seen;
    nf = 0;
    lat = -1;
    r = '0;
    busy_seen = 1'b1;
    @(negedge clock);
    start    = 1'b1;
    operand1 = 32'h40400000;
    operand2 = 32'h40400000;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clock);
      if (j == 1) start = 1'b0;
      if (j == 12) begin
        start    = 1'b1;
        operand1 = 32'h3f800000;
        operand2 = 32'hc2000000;
      end
      if (j == 13) start = 1'b0;
      if (j >= 2 && j <= 29 && !busy_n) busy_seen = 1'b0;
      if (finish_n) begin
        nf++;
        if (lat < 0) begin
          lat = j - 1;
          r = result_n;
        end
      end
    end
    n_cmp++;
    if (nf !== 1 || lat !== 28) begin
      n_err++;
      $display("FAIL busy_ignore_finish: got count=%0d lat=%0d want 1/28", nf, lat);
    end
    n_cmp++;
    if (r !== 32'h41100000) begin
      n_err++;
      $display("FAIL busy_ignore_result: got %h want 41100000", r);
    end
    n_cmp++;
    if (busy_seen !== 1'b1) begin
      n_err++;
      $display("FAIL busy_ignore_busy: busy dropped during operation, want high");
    end
  endtask

  task automatic test_reset_abort();
    int          nf, lat;
    logic [31:0] r_n, r_t;
    logic        il_n, il_t;
    nf = 0;
    @(negedge clock);
    start    = 1'b1;
    operand1 = 32'h40000000;
    operand2 = 32'h40400000;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({result_n, finish_n, illegal_n, busy_n} !== 35'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got %h/%b/%b/%b want 0", result_n, finish_n, illegal_n, busy_n);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      if (finish_n || finish_t || busy_n) nf++;
    end
    n_cmp++;
    if (nf !== 0) begin
      n_err++;
      $display("FAIL abort_no_finish: got %0d active cycles want 0", nf);
    end
    run_op(32'h40000000, 32'hc0900000, r_n, r_t, il_n, il_t, lat);
    n_cmp++;
    if (lat !== 28 || r_n !== 32'hc1100000 || il_n !== 1'b0 || r_t !== 32'hc1100000) begin
      n_err++;
      $display("FAIL abort_next_op: got lat=%0d res=%h/%h ill=%b want 28 c1100000 0", lat, r_n, r_t, il_n);
    end
  endtask

  task automatic test_back_to_back();
    int          lat1, lat2;
    logic [31:0] r1, r2;
    lat1 = -1;
    lat2 = -1;
    r1 = '0;
    r2 = '0;
    @(negedge clock);
    start    = 1'b1;
    operand1 = 32'h40400000;
    operand2 = 32'h3f000000;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (finish_n) begin
        lat1 = j - 1;
        r1 = result_n;
        break;
      end
    end
    operand1 = 32'h40000000;
    operand2 = 32'hc0900000;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (j == 1) start = 1'b0;
      if (finish_n) begin
        lat2 = j - 1;
        r2 = result_n;
        break;
      end
    end
    n_cmp++;
    if (lat1 !== 28 || r1 !== 32'h3fc00000) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d res=%h want 28 3fc00000", lat1, r1);
    end
    n_cmp++;
    if (lat2 !== 28 || r2 !== 32'hc1100000) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d res=%h want 28 c1100000", lat2, r2);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
